// File: rtl/mm2s_readback.sv
// Read-back controller: issues fixed-size MM2S commands, checks each status
// byte, and serializes the 64-bit read stream into bytes for a slow sink.
module mm2s_readback #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [22:0] BTT       = 23'h00_1000,
  parameter int          NUM_CMDS  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_status,
  output logic [71:0] S_AXIS_MM2S_CMD_tdata,
  output logic        S_AXIS_MM2S_CMD_tvalid,
  input  logic        S_AXIS_MM2S_CMD_tready,
  input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
  input  logic        M_AXIS_MM2S_STS_tkeep,
  input  logic        M_AXIS_MM2S_STS_tlast,
  input  logic        M_AXIS_MM2S_STS_tvalid,
  output logic        M_AXIS_MM2S_STS_tready,
  input  logic [63:0] M_AXIS_MM2S_tdata,
  input  logic [7:0]  M_AXIS_MM2S_tkeep,
  input  logic        M_AXIS_MM2S_tlast,
  input  logic        M_AXIS_MM2S_tvalid,
  output logic        M_AXIS_MM2S_tready,
  output logic [7:0]  byte_tdata,
  output logic        byte_tvalid,
  output logic        byte_tlast,
  input  logic        byte_tready,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_STS, DRAIN} state_t;

  localparam logic [15:0] LAST_IDX = 16'(NUM_CMDS - 1);

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [7:0]  err_status_q, err_status_d;
  logic        done_q, done_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_keep_q, hold_keep_d;
  logic        hold_last_q, hold_last_d;
  logic [31:0] byte_count_q, byte_count_d;
  logic        alive_q, alive_d;

  logic start_acc, cmd_hs, sts_hs, sts_good;
  logic empty, last_byte, byte_hs, beat_hs;
  logic unused_sts_sideband;

  assign unused_sts_sideband = ^{M_AXIS_MM2S_STS_tkeep, M_AXIS_MM2S_STS_tlast};

  // Keep bits are contiguous from bit 0, so after shifting the last kept
  // byte is the one whose remaining keep is exactly 1.
  assign empty     = (hold_keep_q == 8'h00);
  assign last_byte = (hold_keep_q == 8'h01);
  assign byte_hs   = !empty && byte_tready;
  assign beat_hs   = M_AXIS_MM2S_tvalid && M_AXIS_MM2S_tready;

  assign start_acc = (state_q == IDLE) && start;
  assign cmd_hs    = S_AXIS_MM2S_CMD_tvalid && S_AXIS_MM2S_CMD_tready;
  assign sts_hs    = M_AXIS_MM2S_STS_tvalid && M_AXIS_MM2S_STS_tready;
  assign sts_good  = M_AXIS_MM2S_STS_tdata[7] && (M_AXIS_MM2S_STS_tdata[6:4] == 3'b000) &&
                     (M_AXIS_MM2S_STS_tdata[3:0] == idx_q[3:0]);

  assign busy                   = (state_q != IDLE);
  assign done                   = done_q;
  assign err                    = err_q;
  assign err_status             = err_status_q;
  assign S_AXIS_MM2S_CMD_tvalid = (state_q == CMD);
  assign S_AXIS_MM2S_CMD_tdata  = S_AXIS_MM2S_CMD_tvalid ?
                                  {4'h0, idx_q[3:0], addr_q, 1'b0, 1'b1, 6'h00, 1'b1, BTT} : 72'h0;
  assign M_AXIS_MM2S_STS_tready = (state_q == WAIT_STS);
  // alive_q holds the data port closed while in reset and for the first cycle out of it.
  assign M_AXIS_MM2S_tready     = alive_q && (empty || (byte_hs && last_byte));
  assign byte_tvalid            = !empty;
  assign byte_tdata             = hold_data_q[7:0];
  assign byte_tlast             = hold_last_q && last_byte;
  assign byte_count             = byte_count_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    err_d        = err_q;
    err_status_d = err_status_q;
    done_d       = 1'b0;
    alive_d      = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = CMD;
          idx_d        = 16'h0000;
          addr_d       = BASE_ADDR;
          err_d        = 1'b0;
          err_status_d = 8'h00;
        end
      end
      CMD: begin
        if (cmd_hs) state_d = WAIT_STS;
      end
      WAIT_STS: begin
        if (sts_hs) begin
          if (!sts_good) begin
            err_d        = 1'b1;
            err_status_d = M_AXIS_MM2S_STS_tdata;
            state_d      = DRAIN;
          end else if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            idx_d   = idx_q + 16'd1;
            addr_d  = addr_q + 32'(BTT);
            state_d = CMD;
          end
        end
      end
      DRAIN: begin
        if (empty && !M_AXIS_MM2S_tvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    byte_count_d = byte_count_q;
    if (beat_hs) begin
      hold_data_d = M_AXIS_MM2S_tdata;
      hold_keep_d = M_AXIS_MM2S_tkeep;
      hold_last_d = M_AXIS_MM2S_tlast;
    end else if (byte_hs) begin
      hold_data_d = {8'h00, hold_data_q[63:8]};
      hold_keep_d = {1'b0, hold_keep_q[7:1]};
    end
    if (start_acc) begin
      byte_count_d = 32'h0;
    end else if (byte_hs) begin
      byte_count_d = byte_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= 16'h0000;
      addr_q       <= 32'h0;
      err_q        <= 1'b0;
      err_status_q <= 8'h00;
      done_q       <= 1'b0;
      hold_data_q  <= 64'h0;
      hold_keep_q  <= 8'h00;
      hold_last_q  <= 1'b0;
      byte_count_q <= 32'h0;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      err_status_q <= err_status_d;
      done_q       <= done_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      byte_count_q <= byte_count_d;
      alive_q      <= alive_d;
    end
  end

endmodule

// File: tb/tb_mm2s_readback.sv
// Bench for mm2s_readback: a datamover responder with random timing, a byte
// sink, and a byte-queue reference model of the expected output stream.
module tb_mm2s_readback;

  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [22:0] BTT        = 23'd16;
  localparam int          NCMD       = 4;
  localparam int          NBEAT      = 2;
  localparam logic [71:0] CMD1_CONST = 72'h01_1000_0010_4080_0010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [7:0]  err_status;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata = 64'h0;
  logic [7:0]  m_tkeep = 8'h00;
  logic        m_tlast = 1'b0;
  logic        m_tvalid = 1'b0;
  logic        m_tready;
  logic [7:0]  byte_tdata;
  logic        byte_tvalid, byte_tlast;
  logic        byte_tready = 1'b0;
  logic [31:0] byte_count;

  mm2s_readback #(.BASE_ADDR(BASE), .BTT(BTT), .NUM_CMDS(NCMD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .err(err), .err_status(err_status),
    .S_AXIS_MM2S_CMD_tdata(cmd_tdata), .S_AXIS_MM2S_CMD_tvalid(cmd_tvalid),
    .S_AXIS_MM2S_CMD_tready(cmd_tready),
    .M_AXIS_MM2S_STS_tdata(s_tdata), .M_AXIS_MM2S_STS_tkeep(1'b1),
    .M_AXIS_MM2S_STS_tlast(1'b1), .M_AXIS_MM2S_STS_tvalid(s_tvalid),
    .M_AXIS_MM2S_STS_tready(s_tready),
    .M_AXIS_MM2S_tdata(m_tdata), .M_AXIS_MM2S_tkeep(m_tkeep), .M_AXIS_MM2S_tlast(m_tlast),
    .M_AXIS_MM2S_tvalid(m_tvalid), .M_AXIS_MM2S_tready(m_tready),
    .byte_tdata(byte_tdata), .byte_tvalid(byte_tvalid), .byte_tlast(byte_tlast),
    .byte_tready(byte_tready), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state and stimulus knobs
  logic [8:0]  exp_q[$];
  int          exp_cnt = 0;
  int          run_cmds = 0;
  logic [71:0] first_cmd = 72'h0;
  bit          pattern = 0, partial = 0, bad_en = 0, early_sts = 0;
  bit          no_gaps = 0, hold_sts = 0, dm_reset = 0;
  int          bad_idx = 0;
  logic [7:0]  bad_val = 8'h00;
  int          sink_mode = 0;
  int          done_cnt = 0;
  bit          m_acc = 0, s_acc = 0;

  function automatic logic [71:0] exp_cmd(input int i);
    logic [31:0] a;
    a = BASE + 32'(i) * 32'(BTT);
    return {4'h0, 4'(i), a, 1'b0, 1'b1, 6'h00, 1'b1, BTT};
  endfunction

  function automatic logic [63:0] beat_data(input int b, input bit last_partial);
    logic [63:0] d;
    if (pattern) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8*b + k);
    end else begin
      d = {$urandom, $urandom};
    end
    if (last_partial) d[23:0] = 24'hCCBBAA;
    return d;
  endfunction

  task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int top;
    top = -1;
    for (int j = 0; j < 8; j++) if (k[j]) top = j;
    for (int j = 0; j < 8; j++) begin
      if (k[j]) begin
        exp_q.push_back({l && (j == top), d[8*j +: 8]});
        exp_cnt++;
      end
    end
  endtask

  task automatic drop_acc();
    if (m_acc) begin m_tvalid = 1'b0; m_acc = 0; end
    if (s_acc) begin s_tvalid = 1'b0; s_acc = 0; end
  endtask

  // Datamover responder: one command, its read beats and its status word.
  task automatic serve_one();
    logic [71:0] c;
    logic [7:0]  sv;
    int          b;
    bit          sdone, lp;
    forever begin
      @(negedge clk);
      drop_acc();
      cmd_tready = 1'b0;
      if (!dm_reset) begin
        cmd_tready = ($urandom_range(0, 2) != 0);
        #1;
        if (cmd_tvalid && cmd_tready) break;
      end
    end
    c = cmd_tdata;
    chk("cmd_word", c, exp_cmd(run_cmds));
    if (run_cmds == 1) chk("cmd1_const", c, CMD1_CONST);
    if (run_cmds == 0) first_cmd = c;
    sv = (bad_en && run_cmds == bad_idx) ? bad_val : {4'h8, 4'(run_cmds)};
    run_cmds++;
    b = 0;
    sdone = 0;
    while (b < NBEAT || !sdone) begin
      @(negedge clk);
      drop_acc();
      cmd_tready = 1'b0;
      if (dm_reset) begin
        m_tvalid = 1'b0; s_tvalid = 1'b0; m_acc = 0; s_acc = 0;
        return;
      end
      if (b < NBEAT && !m_tvalid && (no_gaps || $urandom_range(0, 3) != 0)) begin
        lp       = partial && (b == NBEAT - 1);
        m_tdata  = beat_data(b, lp);
        m_tlast  = (b == NBEAT - 1);
        m_tkeep  = lp ? 8'h07 : 8'hFF;
        m_tvalid = 1'b1;
      end
      if (!sdone && !s_tvalid && !hold_sts && (early_sts || b >= NBEAT - 1) &&
          (m_tvalid || b == NBEAT) && $urandom_range(0, 1) == 1) begin
        s_tdata  = sv;
        s_tvalid = 1'b1;
      end
      #1;
      if (m_tvalid && m_tready) begin
        push_beat(m_tdata, m_tkeep, m_tlast);
        b++;
        m_acc = 1;
      end
      if (s_tvalid && s_tready) begin
        sdone = 1;
        s_acc = 1;
      end
    end
  endtask

  initial forever serve_one();

  // Byte sink compares every delivered byte against the model queue.
  initial begin
    logic [8:0] held;
    logic [8:0] e;
    bit         hold_pend;
    hold_pend = 0;
    held = 9'h0;
    forever begin
      @(negedge clk);
      if (hold_pend && reset_n)
        chk("byte_stable", 72'({byte_tvalid, byte_tlast, byte_tdata}), 72'({1'b1, held}));
      case (sink_mode)
        0:       byte_tready = 1'b1;
        1:       byte_tready = ($urandom_range(0, 3) == 0);
        default: byte_tready = ($urandom_range(0, 7) != 0);
      endcase
      #1;
      hold_pend = 0;
      if (reset_n && byte_tvalid) begin
        if (byte_tready) begin
          if (exp_q.size() == 0) begin
            chk("byte_expected_in_model", 72'(exp_q.size()), 72'd1);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 72'({byte_tlast, byte_tdata}), 72'(e));
          end
        end else begin
          chk("m_tready_while_held", 72'(m_tready), 72'd0);
          hold_pend = 1;
          held = {byte_tlast, byte_tdata};
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic zero_outputs(input string nm);
    chk({nm, "_busy"}, 72'(busy), 72'd0);
    chk({nm, "_done"}, 72'(done), 72'd0);
    chk({nm, "_err"}, 72'(err), 72'd0);
    chk({nm, "_err_status"}, 72'(err_status), 72'd0);
    chk({nm, "_cmd_tvalid"}, 72'(cmd_tvalid), 72'd0);
    chk({nm, "_cmd_tdata"}, cmd_tdata, 72'd0);
    chk({nm, "_sts_tready"}, 72'(s_tready), 72'd0);
    chk({nm, "_m_tready"}, 72'(m_tready), 72'd0);
    chk({nm, "_byte_tvalid"}, 72'(byte_tvalid), 72'd0);
    chk({nm, "_byte_tlast"}, 72'(byte_tlast), 72'd0);
    chk({nm, "_byte_tdata"}, 72'(byte_tdata), 72'd0);
    chk({nm, "_byte_count"}, 72'(byte_count), 72'd0);
  endtask

  task automatic do_run(input string nm, input int exp_cmds, input bit exp_err,
                        input logic [7:0] exp_es);
    int base, n;
    bit got;
    run_cmds = 0;
    exp_cnt  = 0;
    base     = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_t1"}, 72'(busy), 72'd1);
    chk({nm, "_cmd_tvalid_t1"}, 72'(cmd_tvalid), 72'd1);
    chk({nm, "_err_cleared"}, 72'(err), 72'd0);
    chk({nm, "_err_status_cleared"}, 72'(err_status), 72'd0);
    chk({nm, "_count_cleared"}, 72'(byte_count), 72'd0);
    n = 0;
    got = 0;
    while (!got && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) got = 1;
    end
    chk({nm, "_done_seen"}, 72'(got), 72'd1);
    chk({nm, "_busy_with_done"}, 72'(busy), 72'd0);
    repeat (4) @(negedge clk);
    chk({nm, "_done_pulses"}, 72'(done_cnt - base), 72'd1);
    chk({nm, "_err"}, 72'(err), 72'(exp_err));
    chk({nm, "_err_status"}, 72'(err_status), 72'(exp_es));
    chk({nm, "_byte_count"}, 72'(byte_count), 72'(exp_cnt));
    chk({nm, "_bytes_left"}, 72'(exp_q.size()), 72'd0);
    chk({nm, "_cmds_issued"}, 72'(run_cmds), 72'(exp_cmds));
    chk({nm, "_no_extra_cmd"}, 72'(cmd_tvalid), 72'd0);
  endtask

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    zero_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_m_tready", 72'(m_tready), 72'd1);
    chk("idle_busy", 72'(busy), 72'd0);

    pattern = 1; sink_mode = 0;
    do_run("normal", NCMD, 0, 8'h00);

    pattern = 0; sink_mode = 1;
    do_run("backpressure", NCMD, 0, 8'h00);

    sink_mode = 2; bad_en = 1; early_sts = 1; no_gaps = 1;
    bad_idx = 0; bad_val = 8'hC0;
    do_run("slverr", 1, 1, 8'hC0);

    bad_val = 8'h85;
    do_run("tag_mismatch", 1, 1, 8'h85);

    bad_idx = 2; bad_val = {1'b1, 3'($urandom_range(1, 7)), 4'h2};
    do_run("mid_abort", 3, 1, bad_val);

    bad_en = 0; early_sts = 0; no_gaps = 0; partial = 1;
    do_run("partial", NCMD, 0, 8'h00);

    partial = 0; hold_sts = 1; run_cmds = 0; exp_cnt = 0;
    base = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (s_tready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_wait_sts", 72'(s_tready), 72'd1);
    repeat (2) @(negedge clk);
    dm_reset = 1;
    reset_n  = 1'b0;
    #1;
    zero_outputs("midrun_reset");
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_cnt  = 0;
    hold_sts = 0;
    dm_reset = 0;
    reset_n  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 72'(done_cnt - base), 72'd0);
    chk("rst_idle_busy", 72'(busy), 72'd0);
    do_run("after_reset", NCMD, 0, 8'h00);
    chk("after_reset_first_addr", 72'(first_cmd[63:32]), 72'(BASE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
